rx_uart_frame: RTL and testbench
================================

// Module: rx_uart_frame
// PURPOSE
//  Serial receiver for the 11-bit UART frame sent by the team's transmitter:
//  start(0), 8 data bits LSB first, parity, stop(1). Oversamples serial_in,
//  resynchronises it, checks parity and stop, and presents the byte on a
//  one-cycle valid strobe to the MIPS-side UART register block.
// PARAMETERS
//  OVERSAMPLE   16  baud_clk cycles per bit; even, >=4
//  SYNC_STAGES  2   flops in the serial_in synchroniser; >=2
// PORTS
//  baud_clk      in   1  single clock, OVERSAMPLE x bit rate
//  rst           in   1  synchronous, active-high reset
//  serial_in     in   1  asynchronous line input, idles high
//  Parity        in   1  0 = even, 1 = odd; parity bit = ^data ^ Parity
//  parallel_out  out  8  last received byte
//  data_valid    out  1  one-cycle pulse when a frame completes
//  parity_err    out  1  parity mismatch on last frame
//  frame_err     out  1  stop bit sampled 0 on last frame
//  busy          out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset values: parallel_out=0, data_valid=0, parity_err=0, frame_err=0,
//    busy=1. Synchroniser flops reset to 1. State after reset: WAIT_IDLE.
//  - Sample counter cnt counts 0..OVERSAMPLE-1. Bit index counter 0..7.
//  - WAIT_IDLE: stay until synced line = 1, then go to IDLE.
//  - IDLE: synced line = 0 -> cnt=0, go to START.
//  - START: at cnt=OVERSAMPLE/2-1, sample the line. 1 = false start, go to
//    IDLE with no flags changed. 0 = cnt=0, idx=0, go to DATA.
//  - DATA/PARITY/STOP: sample when cnt=OVERSAMPLE-1, i.e. every OVERSAMPLE
//    cycles after the start mid-point. DATA shifts the sample into bit idx,
//    LSB first, and goes to PARITY after idx=7. PARITY stores the bit.
//  - STOP sample: on the next cycle, parallel_out <= shifted byte;
//    parity_err <= (^byte ^ Parity) != parity bit; frame_err <= ~stop;
//    data_valid=1 for exactly that cycle.
//  - The byte is always delivered, even when an error flag is set.
//  - After STOP: stop=1 -> IDLE, so back-to-back frames need no gap.
//    stop=0 (break or framing error) -> WAIT_IDLE.
//  - Error flags hold until the next data_valid, which overwrites them.
//    parallel_out holds until then as well.
//  - Latency: data_valid is SYNC_STAGES + OVERSAMPLE/2 + 10*OVERSAMPLE + 1
//    cycles after the raw falling edge of the start bit.
//  - rst asserted mid-frame aborts the frame with no data_valid. All outputs
//    return to reset values. A line held low after reset is not a start;
//    the receiver first waits in WAIT_IDLE.
//  - No overrun detection. The consumer must take the byte within one frame.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample point is a 2-of-3 majority of the
//    synced line at cnt = mid-1, mid and mid+1. This applies to the start
//    check too. Requires OVERSAMPLE>=4.
//  Not defined: a single sample at the mid-point. Timing is identical either
//    way; the majority voter adds no latency.
// TESTING (OVERSAMPLE=16, SYNC_STAGES=2)
//  1. Parity=0. Send 0xA5 with parity bit 0 and stop 1 -> one data_valid
//     pulse, parallel_out=8'hA5, parity_err=0, frame_err=0. Check the
//     latency equation exactly.
//  2. Parity=1. Send 0x3C with parity bit 0 (correct value is 1) ->
//     parallel_out=8'h3C, parity_err=1. Then a good 0x3C frame -> parity_err=0.
//  3. Send 0x55 with stop=0, then hold the line low 40 cycles -> frame_err=1;
//     busy stays 1 and there is no new start until the line goes high.
//  4. Low glitch of 4 cycles on an idle line -> no data_valid; busy returns
//     to 0 within OVERSAMPLE/2+SYNC_STAGES+1 cycles.
//  5. Back-to-back 0x00 then 0xFF, no idle gap -> two pulses 11*16 cycles
//     apart with the correct bytes. Assert rst at data bit 4 of a third frame
//     -> no pulse, outputs back to reset values.
//  6. With UART_RX_MAJORITY_EN, send 0xF0 with a 1-cycle inversion at the
//     mid-point of bit 2 -> 8'hF0. Without the macro -> 8'hF4.

Source files
------------

// File: rtl/rx_uart_frame.sv
// rx_uart_frame: oversampling receiver for start/8 data LSB-first/parity/stop.
// Optional 2-of-3 majority sampling when UART_RX_MAJORITY_EN is defined.
// Ports:
//   baud_clk     clock, OVERSAMPLE x bit rate
//   rst          synchronous active-high reset
//   serial_in    asynchronous line input, idles high
//   Parity       0 = even, 1 = odd
//   parallel_out last received byte
//   data_valid   one-cycle strobe per completed frame
//   parity_err   parity mismatch on last frame
//   frame_err    stop bit sampled low on last frame
//   busy         high in every state except IDLE
module rx_uart_frame #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       Parity,
  output logic [7:0] parallel_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, START, DATA, PAR, STOP, DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            pbit, pbit_n;
  logic            sbit, sbit_n;
  logic [7:0]      pout_n;
  logic            perr_n, ferr_n, dv_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;
  logic                   smp;

  always_ff @(posedge baud_clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
  end

  assign rx = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // The "mid+1" vote is taken from the previous synchroniser stage,
  // which already holds next cycle's value, so voting costs no latency.
  logic rx_d;
  logic ahead;

  assign ahead = sync_q[SYNC_STAGES-2];

  always_ff @(posedge baud_clk) begin
    if (rst) rx_d <= 1'b1;
    else     rx_d <= rx;
  end

  assign smp = (rx_d & rx) | (rx_d & ahead) | (rx & ahead);
`else
  assign smp = rx;
`endif

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state        <= WAIT_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      pbit         <= 1'b0;
      sbit         <= 1'b0;
      parallel_out <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      pbit         <= pbit_n;
      sbit         <= sbit_n;
      parallel_out <= pout_n;
      parity_err   <= perr_n;
      frame_err    <= ferr_n;
      data_valid   <= dv_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    pbit_n  = pbit;
    sbit_n  = sbit;
    pout_n  = parallel_out;
    perr_n  = parity_err;
    ferr_n  = frame_err;
    dv_n    = 1'b0;
    unique case (state)
      WAIT_IDLE: if (rx) state_n = IDLE;
      IDLE: begin
        if (!rx) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == MID) begin
          if (smp) begin
            state_n = IDLE;
          end else begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = smp;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) state_n = PAR;
        end
      end
      PAR: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          pbit_n  = smp;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          sbit_n  = smp;
          state_n = DONE;
        end
      end
      DONE: begin
        pout_n  = shreg;
        perr_n  = ((^shreg) ^ Parity) != pbit;
        ferr_n  = ~sbit;
        dv_n    = 1'b1;
        // A low stop bit may be a break; wait for the line to recover.
        state_n = sbit ? IDLE : WAIT_IDLE;
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rx_uart_frame.sv
// tb_rx_uart_frame: directed frames into rx_uart_frame, scoreboard checked.
// Expected bytes/flags/latency are queued at stimulus time, popped on data_valid.
module tb_rx_uart_frame;

  localparam int LAT = 2 + 8 + 160 + 1;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] EXP6_B  = 8'hF0;
  localparam logic       EXP6_PE = 1'b0;
`else
  localparam logic [7:0] EXP6_B  = 8'hF4;
  localparam logic       EXP6_PE = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       Parity = 1'b0;
  logic [7:0] parallel_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  rx_uart_frame #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .baud_clk     (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .Parity       (Parity),
    .parallel_out (parallel_out),
    .data_valid   (data_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       pe;
    logic       fe;
    int         t0;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got byte %0h want no pulse",
                 parallel_out);
      end else begin
        e = sbq.pop_front();
        chk("byte", {24'd0, parallel_out}, {24'd0, e.b});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        chk("latency", cyc - e.t0, LAT);
      end
    end
  end

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_pout", {24'd0, parallel_out}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
  endtask

  // k indexes frame bits: 0 start, 1..8 data, 9 parity, 10 stop.
  task automatic send(input logic [7:0] d, input logic pb,
                      input logic sb, input logic [7:0] eb,
                      input logic epe, input logic efe,
                      input int glitch_k, input int abort_k);
    logic [10:0] fr;
    exp_t x;
    fr = {sb, pb, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0 && abort_k < 0) begin
          x.b  = eb;
          x.pe = epe;
          x.fe = efe;
          x.t0 = cyc + 1;
          sbq.push_back(x);
        end
        if (k == abort_k && c == 0) begin
          rst       = 1'b1;
          serial_in = 1'b1;
          @(negedge clk);
          chk_reset_vals();
          rst = 1'b0;
          return;
        end
        if (k == glitch_k && c == 8) serial_in = ~fr[k];
        else                         serial_in = fr[k];
      end
    end
  endtask

  initial begin
    logic saw;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    Parity = 1'b0;
    send(8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, -1, -1);
    idle(20);

    Parity = 1'b1;
    send(8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, -1, -1);
    send(8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, -1, -1);
    idle(20);

    Parity = 1'b0;
    send(8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, -1);
    serial_in = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) saw = 1'b1;
    end
    chk("break_busy_drop", {31'd0, saw}, 32'd0);
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_recover", {31'd0, busy}, 32'd0);
    idle(20);

    serial_in = 1'b0;
    saw = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 5) serial_in = 1'b1;
      if (busy === 1'b1) saw = 1'b1;
    end
    chk("glitch_seen", {31'd0, saw}, 32'd1);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    idle(20);

    send(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, -1, -1);
    send(8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, -1, -1);
    send(8'hAA, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, -1, 5);
    idle(20);
    chk("post_rst_pout", {24'd0, parallel_out}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    send(8'hF0, 1'b0, 1'b1, EXP6_B, EXP6_PE, 1'b0, 3, -1);
    idle(200);
    chk("pending", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
